// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle MIPS core: sequences fetch, decode, execute,
// memory and write-back cycles, counts retired instructions and flags bad opcodes.
module multicycle_control #(
    parameter int unsigned MEM_HANDSHAKE = 1,
    parameter int unsigned CNT_W         = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             mem_read,
    output logic             mem_write,
    output logic             iord,
    output logic             ir_write,
    output logic             pc_write,
    output logic             branch,
    output logic [1:0]       pc_src,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             illegal_op,
    output logic [CNT_W-1:0] retired,
    output logic [3:0]       state_dbg
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             illegal_q, illegal_d;
    logic             ready;
    logic             retire;

    // Without the handshake every memory access is assumed to finish in one cycle.
    assign ready = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;

    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        retire    = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                if (ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                unique case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        state_d   = S_FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                if (ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_MEMWR: begin
                if (ready) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end
            end
            S_EXECUTE: state_d = S_ALUWB;
            S_ALUWB: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_BRANCH: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_ADDIEX: state_d = S_ADDIWB;
            S_ADDIWB: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_JUMP: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // The counter wraps naturally at 2^CNT_W.
    assign retired_d = retire ? (retired_q + CNT_W'(1)) : retired_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_FETCH;
            retired_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
            illegal_q <= illegal_d;
        end
    end

    // Outputs depend only on the state register, so reset forces FETCH values
    // immediately; only the FETCH load strobes look at mem_ready.
    always_comb begin
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        branch     = 1'b0;
        pc_src     = 2'b00;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = ready;
                pc_write  = ready;
            end
            S_DECODE: alu_src_b = 2'b11;
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            S_EXECUTE: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b01;
                branch    = 1'b1;
                pc_src    = 2'b01;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_ADDIWB: reg_write = 1'b1;
            S_JUMP: begin
                pc_write = 1'b1;
                pc_src   = 2'b10;
            end
            default: ;
        endcase
    end

    assign illegal_op = illegal_q;
    assign retired    = retired_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: default instance (a) and a 4-bit counter,
// no-handshake instance (b), checked cycle by cycle against an instruction-level model.
module tb_multicycle_control;

    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;
    localparam logic [3:0] ST_FETCH = 4'd0, ST_DECODE = 4'd1, ST_MEMADR = 4'd2, ST_MEMRD = 4'd3;
    localparam logic [3:0] ST_MEMWB = 4'd4, ST_MEMWR = 4'd5, ST_EXECUTE = 4'd6, ST_ALUWB = 4'd7;
    localparam logic [3:0] ST_BRANCH = 4'd8, ST_ADDIEX = 4'd9, ST_ADDIWB = 4'd10, ST_JUMP = 4'd11;

    logic clk;
    logic rst_a, mem_ready_a, rst_b, mem_ready_b;
    logic [5:0] opcode_a, opcode_b;
    logic mem_read_a, mem_write_a, iord_a, ir_write_a, pc_write_a, branch_a;
    logic alu_src_a_a, reg_write_a, reg_dst_a, mem_to_reg_a, illegal_op_a;
    logic [1:0] pc_src_a, alu_src_b_a, alu_op_a;
    logic [31:0] retired_a;
    logic [3:0] state_dbg_a;
    logic mem_read_b, mem_write_b, iord_b, ir_write_b, pc_write_b, branch_b;
    logic alu_src_a_b, reg_write_b, reg_dst_b, mem_to_reg_b, illegal_op_b;
    logic [1:0] pc_src_b, alu_src_b_b, alu_op_b;
    logic [3:0] retired_b;
    logic [3:0] state_dbg_b;

    multicycle_control dut_a (
        .clk(clk), .rst(rst_a), .opcode(opcode_a), .mem_ready(mem_ready_a),
        .mem_read(mem_read_a), .mem_write(mem_write_a), .iord(iord_a), .ir_write(ir_write_a),
        .pc_write(pc_write_a), .branch(branch_a), .pc_src(pc_src_a), .alu_src_a(alu_src_a_a),
        .alu_src_b(alu_src_b_a), .alu_op(alu_op_a), .reg_write(reg_write_a), .reg_dst(reg_dst_a),
        .mem_to_reg(mem_to_reg_a), .illegal_op(illegal_op_a), .retired(retired_a),
        .state_dbg(state_dbg_a)
    );

    multicycle_control #(.MEM_HANDSHAKE(0), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst_b), .opcode(opcode_b), .mem_ready(mem_ready_b),
        .mem_read(mem_read_b), .mem_write(mem_write_b), .iord(iord_b), .ir_write(ir_write_b),
        .pc_write(pc_write_b), .branch(branch_b), .pc_src(pc_src_b), .alu_src_a(alu_src_a_b),
        .alu_src_b(alu_src_b_b), .alu_op(alu_op_b), .reg_write(reg_write_b), .reg_dst(reg_dst_b),
        .mem_to_reg(mem_to_reg_b), .illegal_op(illegal_op_b), .retired(retired_b),
        .state_dbg(state_dbg_b)
    );

    logic [15:0] outs_a, outs_b;
    assign outs_a = {mem_read_a, mem_write_a, iord_a, ir_write_a, pc_write_a, branch_a, pc_src_a,
                     alu_src_a_a, alu_src_b_a, alu_op_a, reg_write_a, reg_dst_a, mem_to_reg_a};
    assign outs_b = {mem_read_b, mem_write_b, iord_b, ir_write_b, pc_write_b, branch_b, pc_src_b,
                     alu_src_a_b, alu_src_b_b, alu_op_b, reg_write_b, reg_dst_b, mem_to_reg_b};

    // clock/reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;
    int sel = 0;
    logic [31:0] ret_m;
    logic ill_m;
    bit fetch_done = 1'b0;
    int ir_pulses = 0;
    int wr_pulses = 0;
    logic [37:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp_v);
        end
    endtask

    // Control word each state must present, straight from the state descriptions.
    function automatic logic [15:0] exp_outs(input logic [3:0] st, input logic mr, input logic hs);
        logic rd, wr, io, irw, pcw, br, asa, rw, rdst, m2r;
        logic [1:0] pcs, asb, aop;
        {rd, wr, io, irw, pcw, br, asa, rw, rdst, m2r} = '0;
        pcs = 2'b00; asb = 2'b00; aop = 2'b00;
        case (st)
            ST_FETCH:   begin rd = 1; asb = 2'b01; irw = hs ? mr : 1'b1; pcw = irw; end
            ST_DECODE:  asb = 2'b11;
            ST_MEMADR:  begin asa = 1; asb = 2'b10; end
            ST_MEMRD:   begin rd = 1; io = 1; end
            ST_MEMWB:   begin rw = 1; m2r = 1; end
            ST_MEMWR:   begin wr = 1; io = 1; end
            ST_EXECUTE: begin asa = 1; aop = 2'b10; end
            ST_ALUWB:   begin rw = 1; rdst = 1; end
            ST_BRANCH:  begin asa = 1; aop = 2'b01; br = 1; pcs = 2'b01; end
            ST_ADDIEX:  begin asa = 1; asb = 2'b10; end
            ST_ADDIWB:  rw = 1;
            ST_JUMP:    begin pcw = 1; pcs = 2'b10; end
            default: ;
        endcase
        return {rd, wr, io, irw, pcw, br, pcs, asa, asb, aop, rw, rdst, m2r};
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    // driver tasks: one call = one clock cycle of the selected instance
    task automatic step(input logic [3:0] st, input logic mr, input logic [5:0] op);
        @(posedge clk);
        #1;
        if (sel == 0) begin
            mem_ready_a = mr; opcode_a = op;
        end else begin
            mem_ready_b = mr; opcode_b = op;
        end
        exp_q.push_back({st, mr, ill_m, ret_m});
    endtask

    task automatic mem_phase(input logic [3:0] st, input int waits, input logic [5:0] op);
        if (sel == 0) begin
            for (int i = 0; i < waits; i++) step(st, 1'b0, op);
            step(st, 1'b1, op);
        end else begin
            step(st, 1'b0, op);
        end
    endtask

    task automatic run_instr(input logic [5:0] op, input int wf, input int wm);
        logic [5:0] junk;
        junk = 6'($urandom);
        if (!fetch_done) mem_phase(ST_FETCH, wf, junk);
        fetch_done = 1'b0;
        step(ST_DECODE, rbit(), op);
        case (op)
            OP_LW: begin
                step(ST_MEMADR, rbit(), op); mem_phase(ST_MEMRD, wm, op); step(ST_MEMWB, rbit(), op);
                ret_m++;
            end
            OP_SW: begin
                step(ST_MEMADR, rbit(), op); mem_phase(ST_MEMWR, wm, op);
                ret_m++;
            end
            OP_R:    begin step(ST_EXECUTE, rbit(), op); step(ST_ALUWB, rbit(), op); ret_m++; end
            OP_BEQ:  begin step(ST_BRANCH, rbit(), op); ret_m++; end
            OP_ADDI: begin step(ST_ADDIEX, rbit(), op); step(ST_ADDIWB, rbit(), op); ret_m++; end
            OP_J:    begin step(ST_JUMP, rbit(), op); ret_m++; end
            default: ill_m = 1'b1;
        endcase
    endtask

    function automatic logic [5:0] rand_op();
        logic [5:0] ops[6];
        logic [5:0] o;
        int k;
        ops = '{OP_LW, OP_SW, OP_R, OP_BEQ, OP_ADDI, OP_J};
        k = $urandom_range(0, 7);
        if (k < 6) return ops[k];
        do o = 6'($urandom); while (o inside {OP_LW, OP_SW, OP_R, OP_BEQ, OP_ADDI, OP_J});
        return o;
    endfunction

    // scoreboard: compares the selected instance on every modelled cycle
    always @(negedge clk) begin
        logic [37:0] rec;
        logic hs;
        if (exp_q.size() != 0) begin
            rec = exp_q.pop_front();
            hs = (sel == 0);
            if (sel == 0) begin
                chk("state_a", {28'd0, state_dbg_a}, {28'd0, rec[37:34]});
                chk("outs_a", {16'd0, outs_a}, {16'd0, exp_outs(rec[37:34], rec[33], hs)});
                chk("illegal_a", {31'd0, illegal_op_a}, {31'd0, rec[32]});
                chk("retired_a", retired_a, rec[31:0]);
            end else begin
                chk("state_b", {28'd0, state_dbg_b}, {28'd0, rec[37:34]});
                chk("outs_b", {16'd0, outs_b}, {16'd0, exp_outs(rec[37:34], rec[33], hs)});
                chk("illegal_b", {31'd0, illegal_op_b}, {31'd0, rec[32]});
                chk("retired_b", {28'd0, retired_b}, {28'd0, rec[3:0]});
            end
        end
        if (sel == 0 && ir_write_a) ir_pulses++;
        if (sel == 0 && mem_write_a) wr_pulses++;
    end

    task automatic reset_mid_memwr();
        logic [5:0] junk;
        junk = 6'($urandom);
        mem_phase(ST_FETCH, 0, junk);
        step(ST_DECODE, rbit(), OP_SW);
        step(ST_MEMADR, rbit(), OP_SW);
        step(ST_MEMWR, 1'b0, OP_SW);
        step(ST_MEMWR, 1'b0, OP_SW);
        @(posedge clk);
        #1;
        mem_ready_a = 1'b0;
        chk("memwr_wait_req", {31'd0, mem_write_a}, 32'd1);
        #2;
        rst_a = 1'b1;
        #1;
        chk("rst_async_mem_write", {31'd0, mem_write_a}, 32'd0);
        chk("rst_async_state", {28'd0, state_dbg_a}, 32'd0);
        chk("rst_async_retired", retired_a, 32'd0);
        chk("rst_async_mem_read", {31'd0, mem_read_a}, 32'd1);
        ret_m = 0;
        ill_m = 1'b0;
        @(negedge clk);
        #1;
        rst_a = 1'b0;
        chk("post_rst_state", {28'd0, state_dbg_a}, 32'd0);
    endtask

    initial begin
        int c0;
        rst_a = 1'b1; rst_b = 1'b1;
        mem_ready_a = 1'b0; mem_ready_b = 1'b0;
        opcode_a = 6'd0; opcode_b = 6'd0;
        ret_m = 0; ill_m = 1'b0;
        #3;
        chk("reset_state", {28'd0, state_dbg_a}, 32'd0);
        chk("reset_retired", retired_a, 32'd0);
        chk("reset_illegal", {31'd0, illegal_op_a}, 32'd0);
        chk("reset_mem_read", {31'd0, mem_read_a}, 32'd1);
        chk("reset_ir_write", {31'd0, ir_write_a}, 32'd0);
        @(negedge clk);
        #1;
        rst_a = 1'b0;

        run_instr(OP_R, 0, 0);
        chk("rtype_final_state", {28'd0, state_dbg_a}, 32'd7);
        chk("rtype_aluwb_regdst", {30'd0, reg_write_a, reg_dst_a}, 32'd3);
        chk("rtype_retired_before", retired_a, 32'd0);

        ir_pulses = 0;
        c0 = cyc;
        run_instr(OP_LW, 2, 3);
        chk("lw_cycles", cyc - c0, 32'd10);
        chk("lw_final_state", {28'd0, state_dbg_a}, 32'd4);
        chk("lw_memwb_ctl", {30'd0, mem_to_reg_a, reg_write_a}, 32'd3);
        chk("lw_retired_after_rtype", retired_a, 32'd1);
        @(negedge clk);
        #1;
        chk("lw_ir_write_pulses", ir_pulses, 32'd1);

        wr_pulses = 0;
        run_instr(OP_SW, 0, 0);
        chk("sw_final_state", {28'd0, state_dbg_a}, 32'd5);
        run_instr(OP_BEQ, 0, 0);
        chk("beq_ctl", {26'd0, alu_op_a, branch_a, pc_src_a, 1'b0}, {26'd0, 2'b01, 1'b1, 2'b01, 1'b0});
        run_instr(OP_J, 0, 0);
        chk("j_pc_src", {30'd0, pc_src_a}, 32'd2);
        chk("j_retired", retired_a, 32'd4);
        chk("sw_write_pulses", wr_pulses, 32'd1);

        run_instr(6'b111111, 0, 0);
        chk("illegal_in_decode", {31'd0, illegal_op_a}, 32'd0);
        run_instr(OP_R, 0, 0);
        chk("illegal_sticky", {31'd0, illegal_op_a}, 32'd1);
        chk("illegal_not_counted", retired_a, 32'd5);

        reset_mid_memwr();
        run_instr(OP_R, 0, 0);
        chk("after_rst_retired", retired_a, 32'd0);
        chk("after_rst_illegal", {31'd0, illegal_op_a}, 32'd0);

        for (int i = 0; i < 60; i++)
            run_instr(rand_op(), $urandom_range(0, 3), $urandom_range(0, 3));

        // hand over to instance b; its single FETCH cycle starts right at release
        @(negedge clk);
        #1;
        rst_a = 1'b1;
        @(posedge clk);
        #1;
        sel = 1;
        ret_m = 0;
        ill_m = 1'b0;
        rst_b = 1'b0;
        mem_ready_b = 1'b0;
        opcode_b = 6'($urandom);
        exp_q.push_back({ST_FETCH, 1'b0, ill_m, ret_m});
        fetch_done = 1'b1;

        for (int i = 1; i <= 17; i++) begin
            run_instr(OP_ADDI, 0, 0);
            if (i == 16) chk("wrap_before", {28'd0, retired_b}, 32'd15);
            if (i == 17) chk("wrap_zero", {28'd0, retired_b}, 32'd0);
        end
        c0 = cyc;
        run_instr(OP_LW, 0, 0);
        chk("nohs_lw_cycles", cyc - c0, 32'd5);
        chk("nohs_lw_state", {28'd0, state_dbg_b}, 32'd4);
        chk("wrap_one", {28'd0, retired_b}, 32'd1);

        for (int i = 0; i < 20; i++)
            run_instr(rand_op(), 0, 0);

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
